store_ram_ctrl: RTL and testbench

- Parametrised single-port data RAM for the processor datapath.
- Replaces the fixed 32x8 store with configurable width and depth.
- Loads a preset program/data image through a sequential init FSM, one word per cycle.
- Serves load/store requests through a req/ready handshake with registered read data and a read-valid strobe.

---
 rtl/store_ram_pkg.sv | 42 ++++
 rtl/store_ram_array.sv | 71 +++++++
 rtl/store_ram_ctrl.sv | 128 ++++++++++++
 tb/tb_store_ram_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/store_ram_pkg.sv
// Shared definitions for the store RAM controller: FSM state encoding and the
// preset program/data image loaded by the init sweep.
package store_ram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int unsigned IMAGE_LEN = 18;

  // Preset image word for a given address; addresses past the image load zero.
  function automatic logic [7:0] image_word(input logic [31:0] a);
    logic [7:0] w;
    w = 8'h00;
    if (a < IMAGE_LEN) begin
      case (a)
        32'd0:   w = 8'h80;
        32'd1:   w = 8'h3E;
        32'd2:   w = 8'h80;
        32'd3:   w = 8'h3F;
        32'd4:   w = 8'h1E;
        32'd5:   w = 8'h7F;
        32'd6:   w = 8'hB0;
        32'd7:   w = 8'hCC;
        32'd8:   w = 8'h1F;
        32'd9:   w = 8'h7E;
        32'd10:  w = 8'h3F;
        32'd11:  w = 8'hC4;
        32'd12:  w = 8'h1E;
        32'd13:  w = 8'h7F;
        32'd14:  w = 8'h3E;
        32'd15:  w = 8'hC4;
        32'd16:  w = 8'h1E;
        32'd17:  w = 8'hFF;
        default: w = 8'h00;
      endcase
    end
    return w;
  endfunction

endpackage

// File: rtl/store_ram_array.sv
// Single-port synchronous storage with write enable and an enabled read
// register. When STORE_RAM_PARITY_EN is defined an even-parity column is kept
// alongside the data and checked on every read.
module store_ram_array
  import store_ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              we_i,
  input  logic              re_i,
  input  logic              rd_zero_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
`ifdef STORE_RAM_PARITY_EN
  input  logic              inj_i,
  output logic              par_err_o,
`endif
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage write; contents survive reset and are only refreshed by the sweep.
  always_ff @(posedge Clock) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  // Read register: loads only on an accepted read, otherwise holds.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= rd_zero_i ? '0 : mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

`ifdef STORE_RAM_PARITY_EN
  logic par_mem [DEPTH];
  logic par_err_q;

  // Parity column write; inj_i flips the stored bit to force a mismatch.
  always_ff @(posedge Clock) begin
    if (we_i) begin
      par_mem[addr_i] <= (^wdata_i) ^ inj_i;
    end
  end

  // Parity check strobe, aligned with the read data register.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      par_err_q <= 1'b0;
    end else if (re_i && !rd_zero_i) begin
      par_err_q <= (^mem[addr_i]) != par_mem[addr_i];
    end else begin
      par_err_q <= 1'b0;
    end
  end

  assign par_err_o = par_err_q;
`endif

endmodule

// File: rtl/store_ram_ctrl.sv
// Store RAM controller: sweeps the preset image into the array after reset or
// an Initialize request, then serves one load/store per cycle through the
// req/req_ready handshake. Optional parity: define STORE_RAM_PARITY_EN.
//
// state | meaning
// INIT  | writing image word at ptr each cycle, requests refused, busy high
// READY | serving requests; Initialize restarts the sweep
module store_ram_ctrl
  import store_ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Initialize,
  input  logic              req,
  output logic              req_ready,
  input  logic              WE,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_IN,
`ifdef STORE_RAM_PARITY_EN
  input  logic              inj_par,
  output logic              par_err,
`endif
  output logic [DATA_W-1:0] data_Out,
  output logic              rd_valid,
  output logic              busy
);

  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              rd_valid_q, rd_valid_d;

  logic              in_range;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  assign in_range = {1'b0, addr} < DEPTH_L;

  // State, sweep pointer and read strobe registers.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q    <= INIT;
      ptr_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Next state, array port steering and handshake.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rd_valid_d = 1'b0;
    req_ready  = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = addr;
    mem_wdata  = data_IN;
    case (state_q)
      INIT: begin
        // Initialize is ignored here: the sweep always runs to completion.
        mem_we    = 1'b1;
        mem_addr  = ptr_q;
        mem_wdata = DATA_W'(image_word(32'(ptr_q)));
        if (ptr_q == LAST_PTR) begin
          state_d = READY;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      READY: begin
        if (Initialize) begin
          state_d = INIT;
          ptr_d   = '0;
        end else begin
          req_ready = 1'b1;
          if (req) begin
            if (WE) begin
              mem_we = in_range;
            end else begin
              mem_re     = 1'b1;
              rd_valid_d = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = INIT;
        ptr_d   = '0;
      end
    endcase
  end

  assign busy     = (state_q == INIT);
  assign rd_valid = rd_valid_q;

  store_ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .we_i      (mem_we),
    .re_i      (mem_re),
    .rd_zero_i (!in_range),
    .addr_i    (mem_addr),
    .wdata_i   (mem_wdata),
`ifdef STORE_RAM_PARITY_EN
    .inj_i     (inj_par && (state_q == READY)),
    .par_err_o (par_err),
`endif
    .rdata_o   (data_Out)
  );

endmodule

// File: tb/tb_store_ram_ctrl.sv
// Testbench for store_ram_ctrl: directed and random load/store traffic against
// a behavioural memory model, with read results checked by a scoreboard.
module tb_store_ram_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  localparam logic [7:0] IMG [18] = '{
    8'h80, 8'h3E, 8'h80, 8'h3F, 8'h1E, 8'h7F, 8'hB0, 8'hCC, 8'h1F,
    8'h7E, 8'h3F, 8'hC4, 8'h1E, 8'h7F, 8'h3E, 8'hC4, 8'h1E, 8'hFF
  };

  logic          Clock      = 1'b0;
  logic          Reset_n    = 1'b0;
  logic          Initialize = 1'b0;
  logic          req        = 1'b0;
  logic          WE         = 1'b0;
  logic [AW-1:0] addr       = '0;
  logic [DW-1:0] data_IN    = '0;
  logic          req_ready;
  logic [DW-1:0] data_Out;
  logic          rd_valid;
  logic          busy;
`ifdef STORE_RAM_PARITY_EN
  logic          inj_par    = 1'b0;
  logic          par_err;
`endif

  store_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .Initialize (Initialize),
    .req        (req),
    .req_ready  (req_ready),
    .WE         (WE),
    .addr       (addr),
    .data_IN    (data_IN),
`ifdef STORE_RAM_PARITY_EN
    .inj_par    (inj_par),
    .par_err    (par_err),
`endif
    .data_Out   (data_Out),
    .rd_valid   (rd_valid),
    .busy       (busy)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [DW-1:0] d;
    int            cyc;
    logic          perr;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  logic [DW-1:0] mdl_mem [DEPTH];
  bit            mdl_bad [DEPTH];
  int            init_left = 0;
  logic [DW-1:0] mdl_dout  = '0;
  bit            mdl_rv    = 1'b0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic load_image();
    for (int i = 0; i < DEPTH; i++) begin
      mdl_mem[i] = (i < 18) ? DW'(IMG[i]) : '0;
      mdl_bad[i] = 1'b0;
    end
  endtask

  // One clock cycle of stimulus; model advances as of the closing edge.
  task automatic do_cycle(input bit r, input bit w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input bit ini, input bit inj);
    exp_t e;
    req = r; WE = w; addr = a; data_IN = d; Initialize = ini;
`ifdef STORE_RAM_PARITY_EN
    inj_par = inj;
`endif
    @(negedge Clock);
    check("busy", 32'(busy), 32'(init_left > 0));
    check("req_ready", 32'(req_ready), 32'(init_left == 0 && !ini));
    check("rd_valid", 32'(rd_valid), 32'(mdl_rv));
    check("data_Out", 32'(data_Out), 32'(mdl_dout));
    mdl_rv = 1'b0;
    if (init_left > 0) begin
      init_left--;
    end else if (ini) begin
      init_left = DEPTH;
      load_image();
    end else if (r) begin
      if (w) begin
        mdl_mem[a] = d;
`ifdef STORE_RAM_PARITY_EN
        mdl_bad[a] = inj;
`else
        mdl_bad[a] = 1'b0;
`endif
      end else begin
        mdl_rv   = 1'b1;
        mdl_dout = mdl_mem[a];
        e.d      = mdl_mem[a];
        e.cyc    = cyc + 1;
        e.perr   = mdl_bad[a];
        sbq.push_back(e);
      end
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    Reset_n = 1'b0; req = 1'b0; Initialize = 1'b0;
    @(posedge Clock);
    #1;
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_data_Out", 32'(data_Out), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge Clock);
    #1;
    Reset_n   = 1'b1;
    sbq.delete();
    init_left = DEPTH;
    mdl_rv    = 1'b0;
    mdl_dout  = '0;
    load_image();
  endtask

  // Scoreboard monitor: every rd_valid pulse must match the oldest expectation.
  always @(negedge Clock) begin
    if (rd_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: rd_valid with data %0h, none expected (cycle %0d)", data_Out, cyc);
      end else begin
        mon_e = sbq.pop_front();
        check("sb_data", 32'(data_Out), 32'(mon_e.d));
        check("sb_latency", 32'(cyc), 32'(mon_e.cyc));
`ifdef STORE_RAM_PARITY_EN
        check("sb_par_err", 32'(par_err), 32'(mon_e.perr));
`endif
      end
    end
  end

  initial begin
    do_reset();

    // Init sweep: requests and Initialize are ignored throughout.
    for (int i = 0; i < DEPTH; i++) begin
      do_cycle(i[0], 1'b1, AW'(i), 8'hEE, (i == 7), 1'b0);
    end
    idle(1);

    // Image readback including a zero-filled address.
    do_cycle(1'b1, 1'b0, AW'(0), '0, 1'b0, 1'b0);
    do_cycle(1'b1, 1'b0, AW'(5), '0, 1'b0, 1'b0);
    do_cycle(1'b1, 1'b0, AW'(17), '0, 1'b0, 1'b0);
    do_cycle(1'b1, 1'b0, AW'(20), '0, 1'b0, 1'b0);
    idle(2);

    // Write then read the same address back-to-back, then hold.
    do_cycle(1'b1, 1'b1, AW'(3), 8'hA5, 1'b0, 1'b0);
    do_cycle(1'b1, 1'b0, AW'(3), '0, 1'b0, 1'b0);
    idle(3);

    // Initialize restores the image; write during the Initialize cycle is dropped.
    do_cycle(1'b1, 1'b1, AW'(1), 8'h55, 1'b0, 1'b0);
    do_cycle(1'b1, 1'b1, AW'(2), 8'h77, 1'b1, 1'b0);
    idle(DEPTH);
    do_cycle(1'b1, 1'b0, AW'(1), '0, 1'b0, 1'b0);
    do_cycle(1'b1, 1'b0, AW'(2), '0, 1'b0, 1'b0);
    idle(1);

    // Read in flight then reset: reset edge clears rd_valid.
    do_cycle(1'b1, 1'b1, AW'(9), 8'h12, 1'b0, 1'b0);
    do_cycle(1'b1, 1'b0, AW'(9), '0, 1'b0, 1'b0);
    do_reset();
    idle(DEPTH + 1);
    do_cycle(1'b1, 1'b0, AW'(9), '0, 1'b0, 1'b0);

    // Reset in the middle of a sweep restarts it from address 0.
    do_cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    idle(10);
    do_reset();
    idle(DEPTH);
    do_cycle(1'b1, 1'b0, AW'(11), '0, 1'b0, 1'b0);
    idle(1);

`ifdef STORE_RAM_PARITY_EN
    do_cycle(1'b1, 1'b1, AW'(7), 8'h0F, 1'b0, 1'b1);
    do_cycle(1'b1, 1'b0, AW'(7), '0, 1'b0, 1'b0);
    do_cycle(1'b1, 1'b1, AW'(8), 8'h0F, 1'b0, 1'b0);
    do_cycle(1'b1, 1'b0, AW'(8), '0, 1'b0, 1'b0);
    idle(1);
`endif

    // Random traffic with occasional re-initialisation.
    for (int i = 0; i < 500; i++) begin
      do_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               AW'($urandom_range(0, DEPTH - 1)), DW'($urandom),
               ($urandom_range(0, 59) == 0), 1'b0);
    end
    idle(3);

    check("sb_drain", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
